multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_pkg.sv | 77 +++++++
 rtl/multicycle_controller_alu_decoder.sv | 33 +++
 rtl/multicycle_controller.sv | 147 ++++++++++++++
 tb/tb_multicycle_controller.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: opcodes, FSM states,
// mux select codes and ALU control codes used by the controller and the datapath.
package multicycle_controller_pkg;

  // Opcodes
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // FSM state encodings (11-15 are unused and recover to FETCH)
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;

  // Memory address mux
  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  // Result mux
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU source A mux
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  // ALU source B mux
  localparam logic [1:0] SRCB_WDATA = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ALU operation class handed from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Immediate formats
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Moore outputs of one FSM state, before reset masking and branch resolution
  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: turns the FSM's ALU operation class plus instruction fields
// into the 3-bit ALU control code.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    // NOTE: assign a default first so every path drives the output and no latch is inferred.
    alu_control = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op[5]=1) can encode sub; addi with bit 30 set is still add
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control unit: Moore FSM sequencing the shared datapath,
// immediate-format decode, and the ALU decoder sub-module.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic [3:0] state
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  ctrl_t      ctrl;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BEQ:            state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALURESULT;
        ctrl.pc_update  = 1'b1;
        ctrl.aluop      = ALUOP_ADD;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.aluop     = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.aluop     = ALUOP_ADD;
      end
      S_MEMREAD: ctrl.adr_src = ADR_ALUOUT;
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adr_src   = ADR_ALUOUT;
        ctrl.mem_write = 1'b1;
      end
      S_EXECUTER: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_WDATA;
        ctrl.aluop     = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.aluop     = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_WDATA;
        ctrl.aluop     = ALUOP_SUB;
        ctrl.branch    = 1'b1;
      end
      S_JAL: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_update = 1'b1;
        ctrl.aluop     = ALUOP_ADD;
      end
      default: ctrl = '0;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE: imm_src = IMM_S;
      OP_BEQ:   imm_src = IMM_B;
      OP_JAL:   imm_src = IMM_J;
      default:  imm_src = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop       (ctrl.aluop),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

  // Architectural write enables are held off while reset is asserted
  assign pc_write   = ~rst & (ctrl.pc_update | (ctrl.branch & zero));
  assign ir_write   = ~rst & ctrl.ir_write;
  assign mem_write  = ~rst & ctrl.mem_write;
  assign reg_write  = ~rst & ctrl.reg_write;

  assign adr_src    = ctrl.adr_src;
  assign result_src = ctrl.result_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: cycle-by-cycle vector table
// checked through a scoreboard queue, plus instruction-latency sequences.
module tb_multicycle_controller;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] ILL  = 7'b0000000;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] imm_src;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    outs_t      exp;
    string      name;
  } vec_t;

  typedef struct {
    outs_t exp;
    string name;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[$];
  sb_t  sb[$];

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .imm_src     (imm_src),
    .state       (state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic outs_t o(input logic [3:0] st, input logic pcw, input logic adr,
                              input logic mw, input logic irw, input logic rw,
                              input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb_,
                              input logic [2:0] ac, input logic [1:0] imm);
    return '{st, pcw, adr, mw, irw, rw, rs, sa, sb_, ac, imm};
  endfunction

  function automatic outs_t fetch_o(input logic [1:0] imm);
    return o(4'd0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm);
  endfunction

  function automatic outs_t decode_o(input logic [1:0] imm);
    return o(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm);
  endfunction

  function automatic outs_t aluwb_o(input logic [1:0] imm);
    return o(4'd8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, imm);
  endfunction

  task automatic add(input logic r, input logic [6:0] opc, input logic [2:0] f3,
                     input logic f7, input logic z, input outs_t e, input string name);
    vec_t v;
    v.rst = r; v.op = opc; v.funct3 = f3; v.funct7b5 = f7; v.zero = z; v.exp = e; v.name = name;
    vecs.push_back(v);
  endtask

  // Cycles from a FETCH through to the next FETCH for one instruction
  task automatic measure(input logic [6:0] opc, input int exp_lat, input string name);
    int  n;
    bit  done;
    op   = opc;
    n    = 1;
    done = 0;
    for (int i = 0; i < 16 && !done; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (state == 4'd0) done = 1;
      else n++;
    end
    if (!done) $display("FAIL %s_timeout actual=no_fetch required=fetch_within_16", name);
    check(name, n, exp_lat);
  endtask

  initial begin
    outs_t act;
    sb_t   item;

    // Reset held, then lw
    add(1, LW, 3'b000, 0, 0, o(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00), "reset_hold");
    add(0, LW, 3'b000, 0, 0, fetch_o(2'b00), "first_fetch");
    add(0, LW, 3'b000, 0, 0, decode_o(2'b00), "lw_decode");
    add(0, LW, 3'b000, 0, 0, o(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00), "lw_memadr");
    add(0, LW, 3'b000, 0, 0, o(4'd3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00), "lw_memread");
    add(0, LW, 3'b000, 0, 0, o(4'd4, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00), "lw_memwb");
    // R-type sub
    add(0, RT, 3'b000, 1, 0, fetch_o(2'b00), "sub_fetch");
    add(0, RT, 3'b000, 1, 0, decode_o(2'b00), "sub_decode");
    add(0, RT, 3'b000, 1, 0, o(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00), "sub_executer");
    add(0, RT, 3'b000, 1, 0, aluwb_o(2'b00), "sub_aluwb");
    // slti
    add(0, IT, 3'b010, 1, 0, fetch_o(2'b00), "slti_fetch");
    add(0, IT, 3'b010, 1, 0, decode_o(2'b00), "slti_decode");
    add(0, IT, 3'b010, 1, 0, o(4'd7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b101, 2'b00), "slti_executei");
    add(0, IT, 3'b010, 1, 0, aluwb_o(2'b00), "slti_aluwb");
    // beq taken, then not taken
    add(0, BEQ, 3'b000, 0, 1, fetch_o(2'b10), "beq1_fetch");
    add(0, BEQ, 3'b000, 0, 1, decode_o(2'b10), "beq1_decode");
    add(0, BEQ, 3'b000, 0, 1, o(4'd9, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10), "beq_taken");
    add(0, BEQ, 3'b000, 0, 0, fetch_o(2'b10), "beq0_fetch");
    add(0, BEQ, 3'b000, 0, 0, decode_o(2'b10), "beq0_decode");
    add(0, BEQ, 3'b000, 0, 0, o(4'd9, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10), "beq_not_taken");
    // jal
    add(0, JAL, 3'b000, 0, 0, fetch_o(2'b11), "jal_fetch");
    add(0, JAL, 3'b000, 0, 0, decode_o(2'b11), "jal_decode");
    add(0, JAL, 3'b000, 0, 0, o(4'd10, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11), "jal_state");
    add(0, JAL, 3'b000, 0, 0, aluwb_o(2'b11), "jal_aluwb");
    // illegal opcode falls back to FETCH, then sw
    add(0, ILL, 3'b000, 0, 0, fetch_o(2'b00), "ill_fetch");
    add(0, ILL, 3'b000, 0, 0, decode_o(2'b00), "ill_decode");
    add(0, SW, 3'b010, 0, 0, fetch_o(2'b01), "ill_back_to_fetch");
    add(0, SW, 3'b010, 0, 0, decode_o(2'b01), "sw_decode");
    add(0, SW, 3'b010, 0, 0, o(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01), "sw_memadr");
    add(0, SW, 3'b010, 0, 0, o(4'd5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01), "sw_memwrite");
    // reset arriving during MEMWRITE
    add(0, SW, 3'b010, 0, 0, fetch_o(2'b01), "swr_fetch");
    add(0, SW, 3'b010, 0, 0, decode_o(2'b01), "swr_decode");
    add(0, SW, 3'b010, 0, 0, o(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01), "swr_memadr");
    add(1, SW, 3'b010, 0, 0, o(4'd5, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01), "swr_memwrite_masked");
    // addi with bit 30 set stays add
    add(0, IT, 3'b000, 1, 0, fetch_o(2'b00), "after_reset_fetch");
    add(0, IT, 3'b000, 1, 0, decode_o(2'b00), "addi_decode");
    add(0, IT, 3'b000, 1, 0, o(4'd7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00), "addi_b30_executei");
    add(0, IT, 3'b000, 1, 0, aluwb_o(2'b00), "addi_aluwb");
    // R-type and / or
    add(0, RT, 3'b111, 0, 0, fetch_o(2'b00), "and_fetch");
    add(0, RT, 3'b111, 0, 0, decode_o(2'b00), "and_decode");
    add(0, RT, 3'b111, 0, 0, o(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 2'b00), "and_executer");
    add(0, RT, 3'b111, 0, 0, aluwb_o(2'b00), "and_aluwb");
    add(0, RT, 3'b110, 0, 0, fetch_o(2'b00), "or_fetch");
    add(0, RT, 3'b110, 0, 0, decode_o(2'b00), "or_decode");
    add(0, RT, 3'b110, 0, 0, o(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b011, 2'b00), "or_executer");
    add(0, RT, 3'b110, 0, 0, aluwb_o(2'b00), "or_aluwb");
    add(0, LW, 3'b000, 0, 0, fetch_o(2'b00), "final_fetch");

    rst = 1'b1; op = LW; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst = vecs[i].rst; op = vecs[i].op; funct3 = vecs[i].funct3;
      funct7b5 = vecs[i].funct7b5; zero = vecs[i].zero;
      sb.push_back('{vecs[i].exp, vecs[i].name});
      @(negedge clk);
      act = '{state, pc_write, adr_src, mem_write, ir_write, reg_write,
              result_src, alu_src_a, alu_src_b, alu_control, imm_src};
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty actual=0 required=1");
      end else begin
        item = sb.pop_front();
        check(item.name, 32'(act), 32'(item.exp));
      end
    end

    // Latency sequences, each starting from the FETCH cycle
    zero = 1'b0; funct3 = 3'b000; funct7b5 = 1'b0;
    measure(LW,  5, "lat_lw");
    measure(SW,  4, "lat_sw");
    measure(RT,  4, "lat_rtype");
    measure(IT,  4, "lat_itype");
    measure(JAL, 4, "lat_jal");
    measure(BEQ, 3, "lat_beq");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
